uart_tx_arb: RTL and testbench

UART_TX_ARB -- requirements
Module: uart_tx_arb

---
 rtl/uart_tx_arb.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arb.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds single bytes from NREQ requesters into one UART transmitter.
// Transmitter status inputs are synchronized; a per-character timeout aborts a stuck transfer.
module uart_tx_arb #(
    parameter int unsigned NREQ    = 4,
    parameter logic [31:0] TIMEOUT = 32'd200000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_start,
    output logic [7:0]        tx_data,
    input  logic              tx_busy,
    input  logic              tx_clear_req,
    output logic [2:0]        grant_id,
    output logic              arb_busy,
    output logic              done,
    output logic              timeout_err,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StWaitDone,
        StAbort
    } state_e;

    state_e      state_q, state_d;
    logic        busy_s1, busy_s2;
    logic        clr_s1, clr_s2;
    logic [2:0]  last_q, last_d;
    logic [2:0]  grant_q, grant_d;
    logic [7:0]  data_q, data_d;
    logic [31:0] cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        found;
    logic [2:0]  winner;
    int unsigned rr_idx;

    // Search starts one past the last served requester and wraps.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        rr_idx = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            rr_idx = (32'(last_q) + k) % NREQ;
            if (!found && |(req_valid & (NREQ'(1) << rr_idx))) begin
                found  = 1'b1;
                winner = 3'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        grant_d   = grant_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        err_d     = err_q & ~err_clr;
        req_ready = '0;
        tx_start  = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    req_ready = NREQ'(1) << winner;
                    grant_d   = winner;
                    data_d    = 8'(req_data >> {winner, 3'b000});
                    cnt_d     = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                tx_start = 1'b1;
                cnt_d    = cnt_q + 32'd1;
                if (busy_s2 && clr_s2) begin
                    done    = 1'b1;
                    last_d  = grant_q;
                    state_d = StIdle;
                end else if (cnt_q == TIMEOUT - 32'd1) begin
                    state_d = StAbort;
                end else if (busy_s2) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                cnt_d = cnt_q + 32'd1;
                if (clr_s2) begin
                    done    = 1'b1;
                    last_d  = grant_q;
                    state_d = StIdle;
                end else if (cnt_q == TIMEOUT - 32'd1) begin
                    state_d = StAbort;
                end
            end
            StAbort: begin
                err_d   = 1'b1;
                last_d  = grant_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // The accept pulse is combinational from IDLE, so it must be masked while reset is held.
        if (rst) begin
            req_ready = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            busy_s1 <= 1'b0;
            busy_s2 <= 1'b0;
            clr_s1  <= 1'b0;
            clr_s2  <= 1'b0;
            last_q  <= 3'(NREQ - 1);
            grant_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_s1 <= tx_busy;
            busy_s2 <= busy_s1;
            clr_s1  <= tx_clear_req;
            clr_s2  <= clr_s1;
            last_q  <= last_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign tx_data     = data_q;
    assign grant_id    = grant_q;
    assign arb_busy    = (state_q != StIdle);
    assign timeout_err = err_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed and randomized bench for uart_tx_arb; a round-robin model predicts each grant,
// and the bench plays the transmitter side of the handshake.
module tb_uart_tx_arb;

    localparam int unsigned NREQ = 4;
    localparam logic [31:0] TMO  = 32'd100;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;
    logic              tx_clear_req;
    logic [2:0]        grant_id;
    logic              arb_busy;
    logic              done;
    logic              timeout_err;
    logic              err_clr;

    int n_checks = 0;
    int n_errors = 0;
    int last_g;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NREQ   (NREQ),
        .TIMEOUT(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_clear_req(tx_clear_req),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .done        (done),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference arbitration rule: first pending requester after the last one served.
    function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
        for (int k = 1; k <= int'(NREQ); k++) begin
            int i;
            i = (last + k) % int'(NREQ);
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_req_ready"}, req_ready, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_arb_busy"}, arb_busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    // mode 0: normal, 1: busy+clear together in START, 2: stuck transmitter, 3: reset in WAIT_DONE
    task automatic do_char(input logic [NREQ-1:0] v, input logic [8*NREQ-1:0] d, input int mode,
                           input bit clr_in_abort, output int win);
        int         exp_w;
        logic [7:0] exp_b;
        int         n;
        req_valid = v;
        req_data  = d;
        #1;
        exp_w = rr_pick(last_g, v);
        exp_b = d[8*exp_w +: 8];
        win   = exp_w;
        chk("req_ready_grant", req_ready, 1 << exp_w);
        chk("idle_arb_busy", arb_busy, 0);
        tick();
        chk("tx_data_latch", tx_data, exp_b);
        chk("grant_id", grant_id, exp_w);
        chk("tx_start_hi", tx_start, 1);
        chk("req_ready_one_cycle", req_ready, 0);
        req_valid = NREQ'($urandom);
        req_data  = $urandom;
        if (mode == 2) begin
            n = 1;
            forever begin
                tick();
                if (tx_start !== 1'b1 || n > int'(TMO) + 5) break;
                n++;
            end
            chk("abort_start_cycles", n, TMO);
            chk("abort_arb_busy", arb_busy, 1);
            chk("abort_no_done", done, 0);
            if (clr_in_abort) err_clr = 1'b1;
            tick();
            err_clr = 1'b0;
            chk("timeout_err_set", timeout_err, 1);
            chk("abort_to_idle", arb_busy, 0);
            chk("abort_no_done_after", done, 0);
        end else begin
            repeat ($urandom_range(0, 3)) begin
                tick();
                chk("start_hold", tx_start, 1);
            end
            tx_busy = 1'b1;
            if (mode == 1) begin
                tx_clear_req = 1'b1;
                n = 0;
                do begin
                    tick();
                    n++;
                end while (done !== 1'b1 && n < 10);
                chk("same_cycle_done_lat", n, 2);
                chk("same_cycle_in_start", tx_start, 1);
            end else begin
                n = 0;
                do begin
                    tick();
                    n++;
                end while (tx_start !== 1'b0 && n < 10);
                chk("busy_sync_lat", n, 3);
                chk("wait_arb_busy", arb_busy, 1);
                if (mode == 3) begin
                    #2 rst = 1'b1;
                    #1;
                    chk_all_zero("rst_mid");
                    tx_busy   = 1'b0;
                    req_valid = '0;
                    @(posedge clk);
                    #2 rst = 1'b0;
                    tick();
                    last_g = int'(NREQ) - 1;
                    return;
                end
                repeat ($urandom_range(0, 3)) begin
                    req_data = $urandom;
                    tick();
                    chk("wait_no_done", done, 0);
                end
                tx_busy      = 1'b0;
                tx_clear_req = 1'b1;
                n = 0;
                do begin
                    tick();
                    n++;
                end while (done !== 1'b1 && n < 10);
                chk("clear_done_lat", n, 2);
                chk("tx_data_stable", tx_data, exp_b);
            end
            tx_busy      = 1'b0;
            tx_clear_req = 1'b0;
            tick();
            chk("done_one_cycle", done, 0);
            chk("back_to_idle", arb_busy, 0);
        end
        last_g = exp_w;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        int order [5] = '{0, 1, 2, 3, 0};
        rst          = 1'b1;
        req_valid    = '0;
        req_data     = '0;
        tx_busy      = 1'b0;
        tx_clear_req = 1'b0;
        err_clr      = 1'b0;
        last_g       = int'(NREQ) - 1;
        #3;
        chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            do_char('1, $urandom, 0, 1'b0, w);
            chk("contention_order", w, order[i]);
        end

        do_char(4'b0100, 32'h0041_0000, 0, 1'b0, w);
        chk("single_req_id", grant_id, 2);

        do_char('1, $urandom, 1, 1'b0, w);
        do_char(4'b1010, $urandom, 1, 1'b0, w);

        for (int i = 0; i < 16; i++) begin
            do_char(NREQ'($urandom_range(1, (1 << NREQ) - 1)), $urandom,
                    int'($urandom_range(0, 1)), 1'b0, w);
        end

        do_char('1, $urandom, 2, 1'b0, w);
        begin
            int aborted;
            aborted = w;
            do_char('1, $urandom, 0, 1'b0, w);
            chk("after_abort_next", w, (aborted + 1) % int'(NREQ));
        end
        chk("err_sticky", timeout_err, 1);
        req_valid = '0;
        err_clr   = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", timeout_err, 0);

        do_char(4'b0110, $urandom, 2, 1'b1, w);
        chk("err_set_wins", timeout_err, 1);
        req_valid = '0;
        err_clr   = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr2", timeout_err, 0);

        do_char('1, $urandom, 0, 1'b0, w);
        do_char('1, $urandom, 3, 1'b0, w);
        do_char('1, $urandom, 0, 1'b0, w);
        chk("first_after_reset", w, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
